// File: rtl/switch_toggle_pkg.sv
// rtl/switch_toggle_pkg.sv - shared types and constants for the switch toggle bank
package switch_toggle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } sw_state_t;

    localparam int EDGE_RELEASE = 0;
    localparam int EDGE_PRESS   = 1;

endpackage

// File: rtl/switch_toggle_bank_if.sv
// rtl/switch_toggle_bank_if.sv - switch/clear inputs and LED/event outputs of the toggle bank
interface switch_toggle_bank_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] i_Switch;
    logic              i_Clear;
    logic [NUM_CH-1:0] o_LED;
    logic [NUM_CH-1:0] o_Toggle_Pulse;
    logic [NUM_CH-1:0] o_Long_Press;

    modport master (
        output i_Switch,
        output i_Clear,
        input  o_LED,
        input  o_Toggle_Pulse,
        input  o_Long_Press
    );

    modport slave (
        input  i_Switch,
        input  i_Clear,
        output o_LED,
        output o_Toggle_Pulse,
        output o_Long_Press
    );
endinterface

// File: rtl/switch_debounce_ch.sv
// rtl/switch_debounce_ch.sv - two-flop synchroniser and counting debouncer for one switch
module switch_debounce_ch #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Debounced
);
    localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] count;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync_1      <= 1'b0;
            sync_2      <= 1'b0;
            count       <= '0;
            o_Debounced <= 1'b0;
        end else begin
            sync_1 <= i_Switch;
            sync_2 <= sync_1;
            // Any cycle of agreement restarts the qualification window.
            if (sync_2 != o_Debounced) begin
                if (count == CW'(DEBOUNCE_LIMIT - 1)) begin
                    o_Debounced <= sync_2;
                    count       <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end
endmodule

// File: rtl/switch_toggle_bank.sv
// rtl/switch_toggle_bank.sv - multi-channel debounced toggle controller with long-press and clear
module switch_toggle_bank
    import switch_toggle_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int DEBOUNCE_LIMIT   = 250000,
    parameter int LONG_PRESS_LIMIT = 25000000,
    parameter int EDGE_MODE        = EDGE_RELEASE
) (
    input logic                i_Clk,
    input logic                i_Rst,
    switch_toggle_bank_if.slave bus
);
    localparam int HW = $clog2(LONG_PRESS_LIMIT + 1);

    logic [NUM_CH-1:0] led_r;
    logic [NUM_CH-1:0] toggle_r;
    logic [NUM_CH-1:0] long_r;

    assign bus.o_LED          = led_r;
    assign bus.o_Toggle_Pulse = toggle_r;
    assign bus.o_Long_Press   = long_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic          deb;
        logic          deb_q;
        logic          rise;
        logic          fall;
        sw_state_t     state;
        logic [HW-1:0] hold;
        logic          led_q;
        logic          toggle_q;
        logic          long_q;

        switch_debounce_ch #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_debounce (
            .i_Clk      (i_Clk),
            .i_Rst      (i_Rst),
            .i_Switch   (bus.i_Switch[g]),
            .o_Debounced(deb)
        );

        assign rise        = deb & ~deb_q;
        assign fall        = ~deb & deb_q;
        assign led_r[g]    = led_q;
        assign toggle_r[g] = toggle_q;
        assign long_r[g]   = long_q;

        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                deb_q    <= 1'b0;
                state    <= ST_IDLE;
                hold     <= '0;
                led_q    <= 1'b0;
                toggle_q <= 1'b0;
                long_q   <= 1'b0;
            end else begin
                deb_q    <= deb;
                toggle_q <= 1'b0;
                long_q   <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state <= ST_PRESSED;
                            hold  <= '0;
                            if (EDGE_MODE == EDGE_PRESS) begin
                                led_q    <= ~led_q;
                                toggle_q <= 1'b1;
                            end
                        end
                    end
                    ST_PRESSED: begin
                        if (fall) begin
                            state <= ST_IDLE;
                            if (EDGE_MODE == EDGE_RELEASE) begin
                                led_q    <= ~led_q;
                                toggle_q <= 1'b1;
                            end
                        end else if (hold == HW'(LONG_PRESS_LIMIT - 1)) begin
                            state  <= ST_LONG_HELD;
                            long_q <= 1'b1;
                            led_q  <= 1'b0;
                        end else begin
                            hold <= hold + 1'b1;
                        end
                    end
                    ST_LONG_HELD: begin
                        // Release after a long press is swallowed.
                        if (fall) begin
                            state <= ST_IDLE;
                        end else if (hold != HW'(LONG_PRESS_LIMIT)) begin
                            hold <= hold + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
                // Clear wins over any toggle decided above in the same cycle.
                if (bus.i_Clear) begin
                    led_q    <= 1'b0;
                    toggle_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_switch_toggle_bank.sv
// tb/tb_switch_toggle_bank.sv - randomized bench for switch_toggle_bank in both edge modes
module tb_switch_toggle_bank;
    import switch_toggle_pkg::*;

    localparam int NUM_CH = 2;
    localparam int DEB    = 4;
    localparam int LONG   = 20;
    localparam int MAXN   = 4096;
    localparam int CYCLES = 3000;

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b1;

    switch_toggle_bank_if #(.NUM_CH(NUM_CH)) bus_rel ();
    switch_toggle_bank_if #(.NUM_CH(NUM_CH)) bus_prs ();

    switch_toggle_bank #(
        .NUM_CH(NUM_CH), .DEBOUNCE_LIMIT(DEB), .LONG_PRESS_LIMIT(LONG), .EDGE_MODE(EDGE_RELEASE)
    ) dut_rel (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .bus(bus_rel)
    );

    switch_toggle_bank #(
        .NUM_CH(NUM_CH), .DEBOUNCE_LIMIT(DEB), .LONG_PRESS_LIMIT(LONG), .EDGE_MODE(EDGE_PRESS)
    ) dut_prs (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .bus(bus_prs)
    );

    always #5 i_Clk = ~i_Clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: edge-indexed history of raw samples and debounced levels.
    bit rawh[NUM_CH][MAXN];
    bit debh[NUM_CH][MAXN];
    int last_flip[NUM_CH];
    int n;
    int st[2][NUM_CH];
    int entry[2][NUM_CH];
    bit m_led[2][NUM_CH];
    bit m_tp[2][NUM_CH];
    bit m_lp[2][NUM_CH];

    function automatic bit sync_at(int c, int k);
        return (k >= 2) ? rawh[c][k-1] : 1'b0;
    endfunction

    function automatic bit deb_at(int c, int k);
        return (k >= 0) ? debh[c][k] : 1'b0;
    endfunction

    task automatic model_reset();
        n = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            last_flip[c] = 0;
            debh[c][0]   = 1'b0;
            for (int md = 0; md < 2; md++) begin
                st[md][c]    = 0;
                entry[md][c] = 0;
                m_led[md][c] = 1'b0;
                m_tp[md][c]  = 1'b0;
                m_lp[md][c]  = 1'b0;
            end
        end
    endtask

    task automatic model_edge(input logic [NUM_CH-1:0] sw, input bit clr);
        bit prev, flip, rise, fall;
        n++;
        for (int c = 0; c < NUM_CH; c++) begin
            rawh[c][n] = sw[c];
            prev = debh[c][n-1];
            flip = (n - last_flip[c] >= DEB);
            if (flip)
                for (int m = n - DEB + 1; m <= n; m++)
                    if (sync_at(c, m - 1) == prev) flip = 1'b0;
            debh[c][n] = flip ? !prev : prev;
            if (flip) last_flip[c] = n;
            rise = deb_at(c, n - 1) && !deb_at(c, n - 2);
            fall = !deb_at(c, n - 1) && deb_at(c, n - 2);
            for (int md = 0; md < 2; md++) begin
                m_tp[md][c] = 1'b0;
                m_lp[md][c] = 1'b0;
                case (st[md][c])
                    0: if (rise) begin
                        st[md][c]    = 1;
                        entry[md][c] = n;
                        if (md == 1) begin
                            m_led[md][c] = !m_led[md][c];
                            m_tp[md][c]  = 1'b1;
                        end
                    end
                    1: if (fall) begin
                        st[md][c] = 0;
                        if (md == 0) begin
                            m_led[md][c] = !m_led[md][c];
                            m_tp[md][c]  = 1'b1;
                        end
                    end else if (n - entry[md][c] == LONG) begin
                        st[md][c]    = 2;
                        m_lp[md][c]  = 1'b1;
                        m_led[md][c] = 1'b0;
                    end
                    default: if (fall) st[md][c] = 0;
                endcase
                if (clr) begin
                    m_led[md][c] = 1'b0;
                    m_tp[md][c]  = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("rel_led%0d", c),    32'(bus_rel.o_LED[c]),          32'(m_led[0][c]));
            check($sformatf("rel_toggle%0d", c), 32'(bus_rel.o_Toggle_Pulse[c]), 32'(m_tp[0][c]));
            check($sformatf("rel_long%0d", c),   32'(bus_rel.o_Long_Press[c]),   32'(m_lp[0][c]));
            check($sformatf("prs_led%0d", c),    32'(bus_prs.o_LED[c]),          32'(m_led[1][c]));
            check($sformatf("prs_toggle%0d", c), 32'(bus_prs.o_Toggle_Pulse[c]), 32'(m_tp[1][c]));
            check($sformatf("prs_long%0d", c),   32'(bus_prs.o_Long_Press[c]),   32'(m_lp[1][c]));
        end
    endtask

    logic [NUM_CH-1:0] sw;
    bit                clr;
    int                rem[NUM_CH];

    initial begin
        sw = '0;
        clr = 1'b0;
        for (int c = 0; c < NUM_CH; c++) rem[c] = 0;
        bus_rel.i_Switch = '0; bus_rel.i_Clear = 1'b0;
        bus_prs.i_Switch = '0; bus_prs.i_Clear = 1'b0;
        model_reset();
        repeat (2) @(posedge i_Clk);
        #1;
        compare_all();
        @(negedge i_Clk);
        i_Rst = 1'b0;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge i_Clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (rem[c] == 0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        sw[c]  = ~sw[c];
                        rem[c] = $urandom_range(1, 3);
                    end else begin
                        sw[c]  = 1'($urandom_range(0, 1));
                        rem[c] = $urandom_range(5, 45);
                    end
                end
                rem[c]--;
            end
            clr = ($urandom_range(0, 99) < 4);
            bus_rel.i_Switch = sw; bus_rel.i_Clear = clr;
            bus_prs.i_Switch = sw; bus_prs.i_Clear = clr;
            @(posedge i_Clk);
            #1;
            model_edge(sw, clr);
            compare_all();

            // Asynchronous reset between edges; inputs keep their levels through it.
            if (cyc % 700 == 350) begin
                #2;
                i_Rst = 1'b1;
                #1;
                model_reset();
                compare_all();
                @(posedge i_Clk);
                #1;
                i_Rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
